// File: rtl/dist_ram_port_arbiter.sv
// Two-port round-robin front end for a 32x32 registered-output distributed RAM.
// Zero-fills the RAM after reset, then grants one access per cycle with 1-cycle read latency.
module dist_ram_port_arbiter #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  output logic              ram_qspo_ce,
  output logic              ram_qspo_srst,
  input  logic [DATA_W-1:0] ram_qspo,
  output logic              busy
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_A  = DEPTH_W[ADDR_W-1:0] - ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              rr_last, rr_nxt;
  logic              rv0_q, rv1_q, rv0_nxt, rv1_nxt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  always_comb begin
    sel_we    = r1_gnt ? r1_we    : r0_we;
    sel_addr  = r1_gnt ? r1_addr  : r0_addr;
    sel_wdata = r1_gnt ? r1_wdata : r0_wdata;
    in_range  = ({1'b0, sel_addr} < DEPTH_W);
  end

  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    rr_nxt        = rr_last;
    rv0_nxt       = 1'b0;
    rv1_nxt       = 1'b0;
    r0_gnt        = 1'b0;
    r1_gnt        = 1'b0;
    ram_a         = '0;
    ram_d         = '0;
    ram_we        = 1'b0;
    ram_qspo_ce   = 1'b0;
    ram_qspo_srst = 1'b0;
    if (!rst_n) begin
      ram_qspo_srst = 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          ram_we        = 1'b1;
          ram_a         = clr_cnt;
          ram_qspo_srst = 1'b1;
          clr_cnt_nxt   = clr_cnt + ADDR_W'(1);
          if (clr_cnt == LAST_A) state_nxt = S_RUN;
        end
        default: begin
          // On a tie the port that did not win last time goes first.
          r0_gnt = r0_req & (~r1_req | rr_last);
          r1_gnt = r1_req & (~r0_req | ~rr_last);
          if (r0_gnt | r1_gnt) begin
            rr_nxt = r1_gnt;
            ram_a  = sel_addr;
            if (sel_we) begin
              ram_d  = sel_wdata;
              ram_we = in_range;
            end else begin
              // Out-of-range reads clear the output register so they return zero.
              ram_qspo_ce   = 1'b1;
              ram_qspo_srst = ~in_range;
              rv0_nxt       = r0_gnt;
              rv1_nxt       = r1_gnt;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_cnt <= '0;
      rr_last <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      rr_last <= rr_nxt;
      rv0_q   <= rv0_nxt;
      rv1_q   <= rv1_nxt;
    end
  end

  // Gating with rst_n hides a pending read response as soon as reset is asserted.
  assign r0_rvalid = rv0_q & rst_n;
  assign r1_rvalid = rv1_q & rst_n;
  assign r0_rdata  = ram_qspo;
  assign r1_rdata  = ram_qspo;
  assign busy      = (state == S_CLEAR);

endmodule

// File: tb/tb_dist_ram_port_arbiter.sv
// Bench for dist_ram_port_arbiter: behavioural RAM, directed accesses, read-data scoreboard.
module tb_dist_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [5:0]  r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [5:0]  r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic [5:0]  ram_a;
  logic [31:0] ram_d;
  logic        ram_we, ram_qspo_ce, ram_qspo_srst;
  logic [31:0] ram_qspo;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] mem[32];

  always #5 clk = ~clk;

  dist_ram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_qspo_ce(ram_qspo_ce),
    .ram_qspo_srst(ram_qspo_srst), .ram_qspo(ram_qspo), .busy(busy)
  );

  // Registered-output RAM: srst has priority over ce on the output register.
  initial for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | i;
  always @(posedge clk) begin
    if (ram_we) mem[ram_a[4:0]] <= ram_d;
    if (ram_qspo_srst) ram_qspo <= 32'h0;
    else if (ram_qspo_ce) ram_qspo <= mem[ram_a[4:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every read response is matched against the queued expectation.
  always @(negedge clk) begin
    if (r0_rvalid === 1'b1) begin
      if (q0.size() == 0) check("r0 unexpected rvalid", {31'b0, r0_rvalid}, 32'h0);
      else check("r0_rdata", r0_rdata, q0.pop_front());
    end
    if (r1_rvalid === 1'b1) begin
      if (q1.size() == 0) check("r1 unexpected rvalid", {31'b0, r1_rvalid}, 32'h0);
      else check("r1_rdata", r1_rdata, q1.pop_front());
    end
    if (r0_gnt === 1'b1 || r1_gnt === 1'b1)
      check("single grant", {31'b0, r0_gnt & r1_gnt}, 32'h0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drive one request and wait (bounded) for its grant; reads queue the expected data.
  task automatic access(input int p, input logic we, input logic [5:0] a,
                        input logic [31:0] wd, input logic [31:0] exp);
    logic got;
    got = 1'b0;
    if (p == 0) begin r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = wd; end
    else        begin r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = wd; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? r0_gnt : r1_gnt;
    end
    check($sformatf("port%0d grant", p), {31'b0, got}, 32'h1);
    @(posedge clk);
    if (got && !we) begin
      if (p == 0) q0.push_back(exp); else q1.push_back(exp);
    end
    #1;
    r0_req = 1'b0;
    r1_req = 1'b0;
    if (got && !we) begin
      @(negedge clk);
      check($sformatf("port%0d rvalid latency", p), {31'b0, (p == 0) ? r0_rvalid : r1_rvalid}, 32'h1);
      @(posedge clk);
      #1;
    end
  endtask

  // Release reset and check the complete zero-fill sequence.
  task automatic release_and_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("busy after reset", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check($sformatf("clear busy %0d", i), {31'b0, busy}, 32'h1);
      check($sformatf("clear we %0d", i), {31'b0, ram_we}, 32'h1);
      check($sformatf("clear addr %0d", i), {26'b0, ram_a}, i);
      check($sformatf("clear data %0d", i), ram_d, 32'h0);
    end
    @(negedge clk);
    check("busy done", {31'b0, busy}, 32'h0);
    check("we idle", {31'b0, ram_we}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset we", {31'b0, ram_we}, 32'h0);
    check("reset ce", {31'b0, ram_qspo_ce}, 32'h0);
    check("reset srst", {31'b0, ram_qspo_srst}, 32'h1);
    check("reset rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'h0);

    // Zero-fill, then a read of a cleared word.
    release_and_clear();
    access(0, 1'b0, 6'd7, 32'h0, 32'h0);

    // Write then read back on port 0.
    access(0, 1'b1, 6'd5, 32'hDEADBEEF, 32'h0);
    access(0, 1'b0, 6'd5, 32'h0, 32'hDEADBEEF);

    // Out-of-range write must not alias onto address 8.
    access(1, 1'b1, 6'd40, 32'h1, 32'h0);
    access(1, 1'b0, 6'd40, 32'h0, 32'h0);
    access(1, 1'b0, 6'd8, 32'h0, 32'h0);

    // Both ports held with reads: last grant was port 1, so port 0 leads.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 6'd5;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 6'd8;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr r0_gnt %0d", k), {31'b0, r0_gnt}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("rr r1_gnt %0d", k), {31'b0, r1_gnt}, (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k > 0)
        check($sformatf("rr rvalid %0d", k), {31'b0, (k % 2 == 1) ? r0_rvalid : r1_rvalid}, 32'h1);
      @(posedge clk);
      if (k % 2 == 0) q0.push_back(32'hDEADBEEF); else q1.push_back(32'h0);
      if (k == 3) begin #1; r0_req = 1'b0; r1_req = 1'b0; end
    end
    @(negedge clk);
    check("rr last rvalid", {31'b0, r1_rvalid}, 32'h1);
    @(posedge clk);
    #1;

    // Same-cycle write (port 0) and read (port 1) of address 9.
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 6'd9; r0_wdata = 32'h12345678;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 6'd9;
    @(negedge clk);
    check("collide r0_gnt", {31'b0, r0_gnt}, 32'h1);
    check("collide r1_gnt", {31'b0, r1_gnt}, 32'h0);
    @(posedge clk);
    #1;
    r0_req = 1'b0;
    @(negedge clk);
    check("collide r1 second", {31'b0, r1_gnt}, 32'h1);
    @(posedge clk);
    q1.push_back(32'h12345678);
    #1;
    r1_req = 1'b0;
    @(negedge clk);
    check("collide r1 rvalid", {31'b0, r1_rvalid}, 32'h1);
    @(posedge clk);
    #1;

    // Reset right after a read grant: the response is dropped and clear restarts.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 6'd5;
    @(negedge clk);
    check("pre-reset grant", {31'b0, r0_gnt}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("cancelled rvalid", {31'b0, r0_rvalid}, 32'h0);
    check("reset gnt", {31'b0, r0_gnt}, 32'h0);
    check("reset we mid", {31'b0, ram_we}, 32'h0);
    @(posedge clk);
    #1;
    r0_req = 1'b0;
    release_and_clear();
    access(0, 1'b0, 6'd5, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    check("q0 drained", q0.size(), 32'h0);
    check("q1 drained", q1.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
